// File: rtl/bp_pkg.sv
// bp_pkg: types and constants shared by the gshare predictor and its EX-stage resolve unit
package bp_pkg;
  localparam int BP_PC_W = 14;
  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               pred_taken;
    logic [BP_PC_W-1:0] alt_pc;
  } bp_entry_t;
  typedef enum logic {IDLE, FLUSH} bp_res_state_e;
endpackage

// File: rtl/bp_resolve_unit_fifo.sv
// bp_fifo: in-order synchronous FIFO with synchronous clear that overrides push
module bp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head  = mem[rptr];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/bp_resolve_unit.sv
// bp_resolve_unit: matches EX branch outcomes against queued fetch predictions, updates the predictor and recovers on mispredict
module bp_resolve_unit
  import bp_pkg::*;
#(
  parameter int PC_W         = BP_PC_W,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid_F,
  input  logic [PC_W-1:0] pred_pc_F,
  input  logic            pred_taken_F,
  input  logic [PC_W-1:0] pred_alt_pc_F,
  output logic            queue_full,
  input  logic            resolve_valid_EX,
  input  logic            resolve_taken_EX,
  output logic            upd_en,
  output logic [PC_W-1:0] upd_pc,
  output logic            upd_taken,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic            protocol_err
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  bp_res_state_e state, state_nx;
  logic [FC_W-1:0] fcnt, fcnt_nx;
  bp_entry_t head, din;
  logic empty, idle, res, mis, push, err_set;
  assign idle = state == IDLE;
  assign res  = idle && resolve_valid_EX && !empty;
  assign mis  = res && (resolve_taken_EX != head.pred_taken);
  // a correct pop frees the slot, so pushing while full is legal that cycle
  assign push = idle && pred_valid_F && (!queue_full || res);
  assign din  = '{pc: pred_pc_F, pred_taken: pred_taken_F, alt_pc: pred_alt_pc_F};
  assign err_set = idle ? (pred_valid_F && queue_full && !res) || (resolve_valid_EX && empty)
                        : resolve_valid_EX;
  assign flush_busy = !idle;
  bp_fifo #(.W($bits(bp_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (res && !mis),
    .clr   (mis),
    .din   (din),
    .full  (queue_full),
    .empty (empty),
    .head  (head)
  );
  always_comb begin
    state_nx = idle ? (mis ? FLUSH : IDLE) : (fcnt == FC_W'(FLUSH_CYCLES - 1) ? IDLE : FLUSH);
    fcnt_nx  = idle ? '0 : fcnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fcnt         <= '0;
      upd_en       <= 1'b0;
      upd_pc       <= '0;
      upd_taken    <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
      branch_cnt   <= '0;
      mispred_cnt  <= '0;
      protocol_err <= 1'b0;
    end else begin
      state      <= state_nx;
      fcnt       <= fcnt_nx;
      upd_en     <= res;
      mispredict <= mis;
      if (res) begin
        upd_pc    <= head.pc;
        upd_taken <= resolve_taken_EX;
      end
      if (mis) redirect_pc <= head.alt_pc;
      if (res && !(&branch_cnt)) branch_cnt <= branch_cnt + 1'b1;
      if (mis && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + 1'b1;
      if (err_set) protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bp_resolve_unit.sv
// tb_bp_resolve_unit: directed and randomized checks of bp_resolve_unit against a queue-based reference model
module tb_bp_resolve_unit;
  localparam int PW = 14, DEPTH = 4, FC = 2;
  logic clk = 0, rst = 1, pred_valid_F = 0, pred_taken_F = 0, resolve_valid_EX = 0, resolve_taken_EX = 0;
  logic [PW-1:0] pred_pc_F = '0, pred_alt_pc_F = '0;
  logic queue_full, upd_en, upd_taken, mispredict, flush_busy, protocol_err;
  logic [PW-1:0] upd_pc, redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;
  logic n4_full, n4_upd_en, n4_upd_taken, n4_mis, n4_busy, n4_err;
  logic [PW-1:0] n4_upd_pc, n4_red;
  logic [3:0] n4_bc, n4_mc;

  bp_resolve_unit dut (
    .clk(clk), .rst(rst), .pred_valid_F(pred_valid_F), .pred_pc_F(pred_pc_F),
    .pred_taken_F(pred_taken_F), .pred_alt_pc_F(pred_alt_pc_F), .queue_full(queue_full),
    .resolve_valid_EX(resolve_valid_EX), .resolve_taken_EX(resolve_taken_EX),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .flush_busy(flush_busy), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt), .protocol_err(protocol_err)
  );
  bp_resolve_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pred_valid_F(pred_valid_F), .pred_pc_F(pred_pc_F),
    .pred_taken_F(pred_taken_F), .pred_alt_pc_F(pred_alt_pc_F), .queue_full(n4_full),
    .resolve_valid_EX(resolve_valid_EX), .resolve_taken_EX(resolve_taken_EX),
    .upd_en(n4_upd_en), .upd_pc(n4_upd_pc), .upd_taken(n4_upd_taken), .mispredict(n4_mis),
    .redirect_pc(n4_red), .flush_busy(n4_busy), .branch_cnt(n4_bc),
    .mispred_cnt(n4_mc), .protocol_err(n4_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] pc; bit t; logic [PW-1:0] alt; } ent_t;
  ent_t q[$];
  int flush_left, m_bc, m_mc, checks, fails;
  bit m_err, e_upd_en, e_mis, e_ut, e_qfull;
  logic a_qfull;
  logic [PW-1:0] e_upc, e_red;

  // one clock: drive inputs, sample queue_full, advance model, then step past the edge
  task automatic cycle(input bit r, input bit pv, input logic [PW-1:0] ppc, input bit pt,
                       input logic [PW-1:0] palt, input bit rv, input bit rt);
    ent_t h;
    bit popped;
    popped = 0;
    rst = r; pred_valid_F = pv; pred_pc_F = ppc; pred_taken_F = pt; pred_alt_pc_F = palt;
    resolve_valid_EX = rv; resolve_taken_EX = rt;
    #1;
    a_qfull = queue_full;
    e_qfull = q.size() == DEPTH;
    e_upd_en = 0;
    e_mis = 0;
    if (r) begin
      q.delete(); flush_left = 0; m_err = 0; m_bc = 0; m_mc = 0;
    end else if (flush_left == 0) begin
      if (rv) begin
        if (q.size() == 0) m_err = 1;
        else begin
          h = q.pop_front(); popped = 1;
          e_upd_en = 1; e_upc = h.pc; e_ut = rt; m_bc++;
          if (rt != h.t) begin
            e_mis = 1; e_red = h.alt; m_mc++; q.delete(); flush_left = FC;
          end
        end
      end
      if (pv && !e_mis) begin
        if (e_qfull && !popped) m_err = 1;
        else begin h = '{ppc, pt, palt}; q.push_back(h); end
      end
    end else begin
      if (rv) m_err = 1;
      flush_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [PW-1:0] pc, input bit t, input logic [PW-1:0] alt);
    cycle(0, 1, pc, t, alt, 0, 0);
  endtask
  task automatic rslv(input bit rt);
    cycle(0, 0, '0, 0, '0, 1, rt);
  endtask
  task automatic nop();
    cycle(0, 0, '0, 0, '0, 0, 0);
  endtask
  task automatic do_reset();
    cycle(1, 0, '0, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (upd_en !== 1'b0) begin fails++; $display("FAIL reset_upd_en got %b exp 0", upd_en); end
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL reset_mispredict got %b exp 0", mispredict); end
    checks++; if (flush_busy !== 1'b0) begin fails++; $display("FAIL reset_flush_busy got %b exp 0", flush_busy); end
    checks++; if (protocol_err !== 1'b0) begin fails++; $display("FAIL reset_protocol_err got %b exp 0", protocol_err); end
    checks++; if (queue_full !== 1'b0) begin fails++; $display("FAIL reset_queue_full got %b exp 0", queue_full); end
    checks++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin fails++; $display("FAIL reset_counters got %h/%h exp 0/0", branch_cnt, mispred_cnt); end
    checks++; if (upd_pc !== '0 || redirect_pc !== '0 || upd_taken !== 1'b0) begin fails++; $display("FAIL reset_pcs got %h/%h/%b exp 0/0/0", upd_pc, redirect_pc, upd_taken); end
  endtask

  task automatic test_correct();
    logic [PW-1:0] pcs [3];
    bit tk [3];
    pcs = '{14'h10, 14'h20, 14'h30};
    tk = '{1, 0, 1};
    for (int i = 0; i < 3; i++) enq(pcs[i], tk[i], pcs[i] + 14'h4);
    for (int i = 0; i < 3; i++) begin
      rslv(tk[i]);
      checks++; if (upd_en !== 1'b1 || upd_pc !== pcs[i] || upd_taken !== tk[i]) begin fails++; $display("FAIL correct_upd[%0d] got en=%b pc=%h t=%b exp en=1 pc=%h t=%b", i, upd_en, upd_pc, upd_taken, pcs[i], tk[i]); end
      checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL correct_mispredict[%0d] got %b exp 0", i, mispredict); end
    end
    checks++; if (branch_cnt !== 16'd3 || mispred_cnt !== 16'd0) begin fails++; $display("FAIL correct_counters got %0d/%0d exp 3/0", branch_cnt, mispred_cnt); end
    nop();
    checks++; if (upd_en !== 1'b0) begin fails++; $display("FAIL correct_upd_pulse got %b exp 0", upd_en); end
  endtask

  task automatic test_mispredict();
    enq(14'h40, 1, 14'h44);
    enq(14'h50, 0, 14'h54);
    enq(14'h60, 1, 14'h64);
    rslv(0);
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 14'h44) begin fails++; $display("FAIL mis_redirect got mis=%b pc=%h exp mis=1 pc=0044", mispredict, redirect_pc); end
    checks++; if (upd_en !== 1'b1 || upd_taken !== 1'b0 || upd_pc !== 14'h40) begin fails++; $display("FAIL mis_update got en=%b t=%b pc=%h exp 1/0/0040", upd_en, upd_taken, upd_pc); end
    checks++; if (flush_busy !== 1'b1) begin fails++; $display("FAIL mis_flush1 got %b exp 1", flush_busy); end
    checks++; if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd4) begin fails++; $display("FAIL mis_counters got %0d/%0d exp 4/1", branch_cnt, mispred_cnt); end
    enq(14'h70, 0, 14'h74);
    checks++; if (flush_busy !== 1'b1 || mispredict !== 1'b0) begin fails++; $display("FAIL mis_flush2 got busy=%b mis=%b exp 1/0", flush_busy, mispredict); end
    nop();
    checks++; if (flush_busy !== 1'b0) begin fails++; $display("FAIL mis_flush_end got %b exp 0", flush_busy); end
    enq(14'h80, 0, 14'h84);
    rslv(0);
    checks++; if (upd_pc !== 14'h80 || mispredict !== 1'b0) begin fails++; $display("FAIL mis_fifo_cleared got pc=%h mis=%b exp 0080/0", upd_pc, mispredict); end
    checks++; if (protocol_err !== 1'b0) begin fails++; $display("FAIL mis_no_err got %b exp 0", protocol_err); end
  endtask

  task automatic test_full();
    logic [PW-1:0] exp_pc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(14'h100 + 14'(i), i[0], 14'h200 + 14'(i));
    checks++; if (queue_full !== 1'b1 || protocol_err !== 1'b0) begin fails++; $display("FAIL full_flag got full=%b err=%b exp 1/0", queue_full, protocol_err); end
    enq(14'h1FF, 1, 14'h2FF);
    checks++; if (a_qfull !== 1'b1 || protocol_err !== 1'b1) begin fails++; $display("FAIL full_drop got full=%b err=%b exp 1/1", a_qfull, protocol_err); end
    cycle(0, 1, 14'h104, 0, 14'h204, 1, 0);
    checks++; if (a_qfull !== 1'b1 || upd_pc !== 14'h100 || queue_full !== 1'b1) begin fails++; $display("FAIL full_pushpop got pre=%b pc=%h post=%b exp 1/0100/1", a_qfull, upd_pc, queue_full); end
    for (int i = 1; i <= DEPTH; i++) begin
      exp_pc = 14'h100 + 14'(i);
      rslv(i[0]);
      checks++; if (upd_pc !== exp_pc || mispredict !== 1'b0) begin fails++; $display("FAIL full_drain[%0d] got pc=%h mis=%b exp %h/0", i, upd_pc, mispredict, exp_pc); end
    end
    checks++; if (queue_full !== 1'b0) begin fails++; $display("FAIL full_drained got %b exp 0", queue_full); end
  endtask

  task automatic test_empty();
    do_reset();
    rslv(1);
    checks++; if (upd_en !== 1'b0 || mispredict !== 1'b0) begin fails++; $display("FAIL empty_upd got en=%b mis=%b exp 0/0", upd_en, mispredict); end
    checks++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin fails++; $display("FAIL empty_counters got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
    checks++; if (protocol_err !== 1'b1) begin fails++; $display("FAIL empty_err got %b exp 1", protocol_err); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      enq(14'(i), 1, 14'h300 + 14'(i));
      rslv(0);
      nop();
      nop();
    end
    checks++; if (n4_mc !== 4'hF || n4_bc !== 4'hF) begin fails++; $display("FAIL sat_cnt4 got %h/%h exp f/f", n4_bc, n4_mc); end
    checks++; if (mispred_cnt !== 16'd18 || branch_cnt !== 16'd18) begin fails++; $display("FAIL sat_cnt16 got %0d/%0d exp 18/18", branch_cnt, mispred_cnt); end
    checks++; if (redirect_pc !== 14'h311) begin fails++; $display("FAIL sat_redirect got %h exp 0311", redirect_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enq(14'h55, 1, 14'h66);
    rslv(0);
    checks++; if (mispredict !== 1'b1 || flush_busy !== 1'b1) begin fails++; $display("FAIL rmid_pre got mis=%b busy=%b exp 1/1", mispredict, flush_busy); end
    cycle(1, 0, '0, 0, '0, 0, 0);
    checks++; if (mispredict !== 1'b0 || upd_en !== 1'b0 || flush_busy !== 1'b0) begin fails++; $display("FAIL rmid_outputs got mis=%b en=%b busy=%b exp 0/0/0", mispredict, upd_en, flush_busy); end
    checks++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 || protocol_err !== 1'b0) begin fails++; $display("FAIL rmid_counters got %0d/%0d/%b exp 0/0/0", branch_cnt, mispred_cnt, protocol_err); end
    enq(14'h77, 0, 14'h78);
    rslv(0);
    checks++; if (upd_en !== 1'b1 || upd_pc !== 14'h77) begin fails++; $display("FAIL rmid_idle got en=%b pc=%h exp 1/0077", upd_en, upd_pc); end
  endtask

  task automatic test_random();
    bit r, pv, rv, rt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 99) == 0;
      pv = $urandom_range(0, 1) == 1;
      rv = $urandom_range(0, 2) == 0;
      rt = q.size() > 0 ? q[0].t ^ ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
      cycle(r, pv, 14'($urandom), 1'($urandom_range(0, 1)), 14'($urandom), rv, rt);
      checks++; if (a_qfull !== e_qfull) begin fails++; $display("FAIL rnd_full[%0d] got %b exp %b", n, a_qfull, e_qfull); end
      checks++; if (upd_en !== e_upd_en || mispredict !== e_mis) begin fails++; $display("FAIL rnd_pulse[%0d] got en=%b mis=%b exp %b/%b", n, upd_en, mispredict, e_upd_en, e_mis); end
      checks++; if (flush_busy !== (flush_left > 0) || protocol_err !== m_err) begin fails++; $display("FAIL rnd_state[%0d] got busy=%b err=%b exp %b/%b", n, flush_busy, protocol_err, flush_left > 0, m_err); end
      checks++; if (branch_cnt !== 16'(m_bc) || mispred_cnt !== 16'(m_mc)) begin fails++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", n, branch_cnt, mispred_cnt, m_bc, m_mc); end
      checks++; if (n4_bc !== 4'(m_bc > 15 ? 15 : m_bc) || n4_mc !== 4'(m_mc > 15 ? 15 : m_mc)) begin fails++; $display("FAIL rnd_cnt4[%0d] got %0d/%0d exp sat of %0d/%0d", n, n4_bc, n4_mc, m_bc, m_mc); end
      if (e_upd_en) begin
        checks++; if (upd_pc !== e_upc || upd_taken !== e_ut) begin fails++; $display("FAIL rnd_upd[%0d] got %h/%b exp %h/%b", n, upd_pc, upd_taken, e_upc, e_ut); end
      end
      if (e_mis) begin
        checks++; if (redirect_pc !== e_red) begin fails++; $display("FAIL rnd_redirect[%0d] got %h exp %h", n, redirect_pc, e_red); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_empty();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/bp_resolve_unit.md
# bp_resolve_unit

Execute-stage counterpart of the gshare predictor. Captures each fetch-stage prediction in an in-order queue, pops the oldest entry when a branch resolves in EX, and compares the prediction with the actual outcome. Drives the predictor's update port (enable, PC, result). On a mispredict, issues a redirect PC and a wrong-path flush. Sits between the fetch-stage predictor lookup and the EX branch comparator.

## Interface
- `PC_W`, 14: PC width, matches the predictor index width.
- `DEPTH`, 4: maximum in-flight predicted branches; power of two, ≥2.
- `FLUSH_CYCLES`, 2: cycles the unit stays in FLUSH after a mispredict; ≥1.
- `CNT_W`, 16: width of the statistics counters.

Ports (reset values in brackets):
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `pred_valid_F` in 1: a branch was predicted in fetch this cycle.
- `pred_pc_F` in PC_W: PC of that branch.
- `pred_taken_F` in 1: predictor decision (BP_decision).
- `pred_alt_pc_F` in PC_W: PC of the path not chosen, used as the recovery target.
- `queue_full` out 1 [0]: combinational from occupancy; fetch must stall predicted branches while it is high.
- `resolve_valid_EX` in 1: the oldest in-flight branch resolves this cycle.
- `resolve_taken_EX` in 1: actual outcome.
- `upd_en` out 1 [0]: one-cycle pulse to predictor branch_en_EX.
- `upd_pc` out PC_W [0]: PC to update.
- `upd_taken` out 1 [0]: outcome to predictor branch_result.
- `mispredict` out 1 [0]: one-cycle pulse.
- `redirect_pc` out PC_W [0]: valid while `mispredict` is high.
- `flush_busy` out 1 [0]: high while in FLUSH.
- `branch_cnt` out CNT_W [0]: resolved branches, saturating.
- `mispred_cnt` out CNT_W [0]: mispredicts, saturating.
- `protocol_err` out 1 [0]: sticky until reset.

## Operation
- FIFO entry fields: {pc, pred_taken, alt_pc}.
- Enqueue when `pred_valid_F && !queue_full` and state is IDLE.
  - `pred_valid_F` while full: entry dropped, `protocol_err` set.
- Resolve (IDLE, `resolve_valid_EX`):
  - Pop the head.
  - Register `upd_en=1`, `upd_pc=head.pc`, `upd_taken=resolve_taken_EX`.
  - Increment `branch_cnt`.
  - If `resolve_taken_EX != head.pred_taken`, it is a mispredict:
    - `mispredict=1`, `redirect_pc=head.alt_pc`.
    - Increment `mispred_cnt`.
    - Clear the whole FIFO; all younger entries are wrong-path.
    - Go to FLUSH.
- Resolve with empty FIFO: no update and no counter change; `protocol_err` set.
- Same-cycle enqueue and correct resolve: both take effect, occupancy unchanged. This is legal when full, since the pop frees the slot, but `queue_full` is still reported high that cycle.
- Same-cycle enqueue and mispredicting resolve: the enqueue is discarded (wrong-path) and the FIFO ends empty.
- FSM:
  - IDLE → FLUSH on a mispredict.
  - FLUSH counts FLUSH_CYCLES cycles, then → IDLE.
  - In FLUSH: `flush_busy=1`, enqueues ignored silently, resolves ignored and `protocol_err` set.
- Counters saturate at all-ones and never wrap.
- Pointer arithmetic is modulo DEPTH; occupancy counter is `$clog2(DEPTH)+1` bits.

## Timing
- `upd_*`, `mispredict`, `redirect_pc`: registered, asserted exactly 1 cycle after the resolve cycle, held for 1 cycle. `upd_pc`/`upd_taken` may hold stale values when `upd_en=0`.
- Counters reflect a resolve 1 cycle after it.
- `flush_busy` rises in the same cycle as `mispredict` and stays high FLUSH_CYCLES cycles.
- Enqueue accepted in cycle N is poppable by a resolve in cycle N+1.
- `rst` mid-operation: next cycle FIFO empty, state IDLE, all outputs at reset values, including the in-flight `upd_en`/`mispredict` pulse.

## Structure
- Shared package `bp_pkg` holds:
  - `bp_entry_t` packed struct (pc, pred_taken, alt_pc), parameterised via PC_W constant.
  - `bp_res_state_e` enum {IDLE, FLUSH}.
  - `BP_PC_W` default constant, shared with the predictor.
- Sub-module `bp_fifo`: synchronous FIFO with push, pop, synchronous clear, full, empty and head output. Clear has priority over push in the same cycle.

## Test plan
- Reset, then 3 enqueues (pc 0x10/0x20/0x30, taken 1/0/1), then 3 correct resolves: 3 `upd_en` pulses with upd_pc 0x10/0x20/0x30; `branch_cnt=3`, `mispred_cnt=0`, no `mispredict`.
- Enqueue pc 0x40 taken=1 alt 0x44, plus 2 younger entries; resolve taken=0:
  - next cycle `mispredict=1`, `redirect_pc=0x44`, `upd_taken=0`;
  - FIFO empty, `flush_busy` high 2 cycles;
  - enqueues during flush ignored.
- Fill to DEPTH=4, `pred_valid_F` again: `queue_full=1`, entry dropped, `protocol_err=1`. Same-cycle push with correct pop at full: occupancy stays 4.
- `resolve_valid_EX` with empty FIFO: no `upd_en`, counters unchanged, `protocol_err=1`.
- Force `mispred_cnt` near 0xFFFF through repeated mispredicts, using a reduced CNT_W=4 build: saturates at 0xF.
- Assert `rst` the cycle after a mispredicting resolve: `mispredict`/`upd_en` low next cycle, state IDLE, counters 0.
